// File: rtl/fp32_add_sub.sv
// fp32_add_sub: binary32 adder/subtractor with a registered result and an overflow flag, one cycle of latency.
module fp32_add_sub (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] out,
    output logic        o
);
    logic [31:0] w_b, w_x, w_y, w_res;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_ovf, w_up;
    logic [7:0]  w_d;
    logic [50:0] w_mx, w_my, w_sum, w_norm;
    logic [5:0]  w_lz;
    logic [24:0] w_rnd;
    logic [9:0]  w_exp;
    logic [31:0] r_out;
    logic        r_o;
    assign w_b      = b ^ {op, 31'b0};
    assign w_a_nan  = (&a[30:23]) && (|a[22:0]);
    assign w_b_nan  = (&w_b[30:23]) && (|w_b[22:0]);
    assign w_a_inf  = (&a[30:23]) && !(|a[22:0]);
    assign w_b_inf  = (&w_b[30:23]) && !(|w_b[22:0]);
    assign w_a_zero = a[30:23] == 8'd0;
    assign w_b_zero = w_b[30:23] == 8'd0;
    assign w_x      = (a[30:0] >= w_b[30:0]) ? a : w_b;
    assign w_y      = (a[30:0] >= w_b[30:0]) ? w_b : a;
    assign w_d      = w_x[30:23] - w_y[30:23];
    // 26 spare low bits keep alignment exact up to d=26; beyond that the smaller operand is a lone sticky bit
    assign w_mx     = {2'b01, w_x[22:0], 26'b0};
    assign w_my     = (w_d > 8'd26) ? 51'd1 : ({2'b01, w_y[22:0], 26'b0} >> w_d);
    assign w_sum    = (w_x[31] == w_y[31]) ? w_mx + w_my : w_mx - w_my;
    always_comb begin
        w_lz = 6'd0;
        for (int i = 0; i < 51; i++)
            if (w_sum[i]) w_lz = 6'(50 - i);
    end
    // leading one lands on bit 50: mantissa [50:27], guard [26], sticky [25:0]
    assign w_norm   = w_sum << w_lz;
    assign w_up     = w_norm[26] & ((|w_norm[25:0]) | w_norm[27]);
    assign w_rnd    = {1'b0, w_norm[50:27]} + {24'b0, w_up};
    assign w_exp    = {2'b0, w_x[30:23]} + 10'd1 + {9'b0, w_rnd[24]} - {4'b0, w_lz};
    always_comb begin
        w_res = 32'h0;
        w_ovf = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && a[31] != w_b[31])) w_res = 32'h7FC00000;
        else if (w_a_inf) w_res = a;
        else if (w_b_inf) w_res = w_b;
        else if (w_a_zero && w_b_zero) w_res = {a[31] & w_b[31], 31'b0};
        else if (w_a_zero) w_res = w_b;
        else if (w_b_zero) w_res = a;
        else if (w_sum == 51'd0) w_res = 32'h0;
        else if (w_exp[9] || w_exp == 10'd0) w_res = {w_x[31], 31'b0};
        else if (w_exp >= 10'd255) begin
            w_res = {w_x[31], 8'hFF, 23'b0};
            w_ovf = 1'b1;
        end
        else w_res = {w_x[31], w_exp[7:0], w_rnd[22:0]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= 32'h0;
            r_o   <= 1'b0;
        end else begin
            r_out <= w_res;
            r_o   <= w_ovf;
        end
    end
    assign out = r_out;
    assign o   = r_o;
endmodule

// File: tb/tb_fp32_add_sub.sv
// tb_fp32_add_sub: directed and randomized checks of fp32_add_sub against an exact big-integer model.
module tb_fp32_add_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        op = 1'b0;
    logic [31:0] out;
    logic        o;
    int          checks = 0;
    int          failures = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        logic        ov;
    } vec_t;

    vec_t dir_v [8] = '{
        '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0},
        '{32'h0DEEEE00, 32'h0DEE0000, 1'b0, 32'h0E6E7700, 1'b0},
        '{32'hF5550005, 32'h7555000D, 1'b1, 32'hF5D50009, 1'b0},
        '{32'hFEE30099, 32'h7DE00090, 1'b0, 32'hFEAB0075, 1'b0},
        '{32'hD5551255, 32'hD5551250, 1'b1, 32'hCAA00000, 1'b0},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0},
        '{32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 1'b0}
    };

    vec_t spc_v [16] = '{
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0},
        '{32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000, 1'b0},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0},
        '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0},
        '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0},
        '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0},
        '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0},
        '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0},
        '{32'hC0400000, 32'h00000000, 1'b0, 32'hC0400000, 1'b0},
        '{32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 1'b0},
        '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0},
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0},
        '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0},
        '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1},
        '{32'h7F7FFFFF, 32'h72FFFFFF, 1'b0, 32'h7F7FFFFF, 1'b0}
    };

    always #5 clk = ~clk;

    fp32_add_sub dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .op(op),
        .out(out),
        .o(o)
    );

    // Exact sum as a wide integer in units of 2^-149, then rounded to 24 significant bits.
    function automatic logic [32:0] ref_model(input logic [31:0] x, input logic [31:0] y0, input logic p);
        logic [31:0]  y;
        logic [279:0] mx, my, t, rem, half, one;
        logic [24:0]  q;
        logic         s, xn, yn, xi, yi, xz, yz;
        int           pos, e, sh;
        y  = y0 ^ {p, 31'b0};
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xz = x[30:23] == 8'h00;
        yz = y[30:23] == 8'h00;
        if (xn || yn || (xi && yi && x[31] != y[31])) return {1'b0, 32'h7FC00000};
        if (xi) return {1'b0, x};
        if (yi) return {1'b0, y};
        if (xz && yz) return {1'b0, x[31] & y[31], 31'b0};
        if (xz) return {1'b0, y};
        if (yz) return {1'b0, x};
        mx = 280'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1);
        my = 280'({1'b1, y[22:0]}) << (int'(y[30:23]) - 1);
        if (x[31] == y[31]) begin
            t = mx + my;
            s = x[31];
        end else if (mx == my) begin
            return 33'd0;
        end else if (mx > my) begin
            t = mx - my;
            s = x[31];
        end else begin
            t = my - mx;
            s = y[31];
        end
        pos = 0;
        for (int i = 0; i < 280; i++) if (t[i]) pos = i;
        e = pos - 22;
        if (e <= 0) return {1'b0, s, 31'b0};
        sh   = pos - 23;
        one  = 280'd1;
        q    = 25'(t >> sh);
        rem  = t & ((one << sh) - one);
        half = (sh > 0) ? (one << (sh - 1)) : 280'd0;
        if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 25'd1;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'b0};
        return {1'b0, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] ref_v, input bit near);
        logic [31:0] r;
        int          k, e;
        r = $urandom;
        k = int'($urandom_range(0, 19));
        if (k == 0) r[30:0] = 31'd0;
        else if (k == 1) r[30:23] = 8'd0;
        else if (k == 2) r[30:0] = {8'hFF, 23'd0};
        else if (k == 3) begin
            r[30:23] = 8'hFF;
            r[0] = 1'b1;
        end
        else if (k == 4) r[30:0] = ref_v[30:0];
        else if (k == 5) r[30:23] = 8'hFE;
        else begin
            e = near ? int'(ref_v[30:23]) + int'($urandom_range(0, 6)) - 3 : int'($urandom_range(1, 254));
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            r[30:23] = 8'(e);
            if (near && k[0]) r[22:0] = ref_v[22:0] ^ 23'($urandom & 32'hFF);
        end
        return r;
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic p);
        @(negedge clk);
        a = x;
        b = y;
        op = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (out !== 32'h0 || o !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial out=%h o=%b expected out=00000000 o=0", out, o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(32'h3F800000, 32'h3F800000, 1'b0);
        checks++;
        if (out !== 32'h40000000 || o !== 1'b0) begin
            failures++;
            $display("FAIL reset_pre out=%h o=%b expected out=40000000 o=0", out, o);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0 || o !== 1'b0) begin
            failures++;
            $display("FAIL reset_async out=%h o=%b expected out=00000000 o=0", out, o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== 32'h0 || o !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold out=%h o=%b expected out=00000000 o=0", out, o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(32'h3F800000, 32'h3F800000, 1'b0);
        checks++;
        if (out !== 32'h40000000 || o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release out=%h o=%b expected out=40000000 o=0", out, o);
        end
    endtask

    task automatic test_directed;
        for (int i = 0; i < 8; i++) begin
            drive(dir_v[i].a, dir_v[i].b, dir_v[i].op);
            checks++;
            if (out !== dir_v[i].r || o !== dir_v[i].ov) begin
                failures++;
                $display("FAIL directed[%0d] a=%h b=%h op=%b out=%h o=%b expected out=%h o=%b",
                         i, dir_v[i].a, dir_v[i].b, dir_v[i].op, out, o, dir_v[i].r, dir_v[i].ov);
            end
        end
    endtask

    task automatic test_specials;
        for (int i = 0; i < 16; i++) begin
            drive(spc_v[i].a, spc_v[i].b, spc_v[i].op);
            checks++;
            if (out !== spc_v[i].r || o !== spc_v[i].ov) begin
                failures++;
                $display("FAIL special[%0d] a=%h b=%h op=%b out=%h o=%b expected out=%h o=%b",
                         i, spc_v[i].a, spc_v[i].b, spc_v[i].op, out, o, spc_v[i].r, spc_v[i].ov);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        logic        p;
        logic [32:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            x = rand_op(32'h3F800000, 1'b0);
            y = rand_op(x, ($urandom_range(0, 1) == 1));
            p = 1'($urandom_range(0, 1));
            exp_v = ref_model(x, y, p);
            drive(x, y, p);
            checks++;
            if ({o, out} !== exp_v) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h op=%b out=%h o=%b expected out=%h o=%b",
                         i, x, y, p, out, o, exp_v[31:0], exp_v[32]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x, y, px, py;
        logic        p, pp;
        logic [32:0] exp_v;
        exp_v = 33'd0;
        px = 32'h0;
        py = 32'h0;
        pp = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({o, out} !== exp_v) begin
                    failures++;
                    $display("FAIL b2b[%0d] a=%h b=%h op=%b out=%h o=%b expected out=%h o=%b",
                             i - 1, px, py, pp, out, o, exp_v[31:0], exp_v[32]);
                end
            end
            if (i < 200) begin
                x = rand_op(32'h40000000, 1'b0);
                y = rand_op(x, 1'b1);
                p = 1'($urandom_range(0, 1));
                a = x;
                b = y;
                op = p;
                exp_v = ref_model(x, y, p);
                px = x;
                py = y;
                pp = p;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_specials();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp32_add_sub.md
Name: fp32_add_sub

Overview:
- Single-precision IEEE-754 floating-point adder/subtractor with a registered result.
- Computes a+b when op=0 and a−b when op=1.
- Flags exponent overflow.
- Used as a one-cycle-latency arithmetic datapath stage.

Parameters:
- None. The format is fixed at binary32: 1 sign bit, 8 exponent bits, 23 fraction bits, bias 127.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset.
- a  input  32  Operand A, IEEE-754 single precision.
- b  input  32  Operand B, IEEE-754 single precision.
- op  input  1  0 = add (a+b); 1 = subtract (a−b).
- out  output  32  Registered IEEE-754 result.
- o  output  1  Registered overflow flag.

Behaviour:
- Reset: when rst=1, out=32'h00000000 and o=0 immediately (asynchronous). Both hold while rst is asserted.
- Latency: out and o update on the first rising clk edge after a, b and op are applied.
  - The computation itself is combinational from a, b and op.
  - New operands are accepted every cycle; there is no handshake.
- Subtract handling: invert b's sign when op=1, then perform signed-magnitude addition.
- Alignment:
  - Compare the operand magnitudes; the larger-magnitude operand sets the result sign and exponent.
  - Right-shift the smaller significand (hidden bit included) by the exponent difference.
  - Keep guard, round and sticky bits.
  - Exponent difference ≥ 26: the smaller operand contributes only to sticky.
- Same effective sign: add the significands. On carry-out, shift right 1 and increment the exponent.
- Opposite effective signs: subtract the smaller magnitude from the larger. Normalize with a leading-zero count and left shift, decrementing the exponent.
- Rounding: round-to-nearest-even using guard, round and sticky. A mantissa carry from rounding renormalizes and increments the exponent.
- Overflow: a final biased exponent ≥ 255 with finite inputs gives out = signed infinity (0x7F800000 / 0xFF800000) and o=1. Otherwise o=0.
- Underflow/denormals:
  - Denormal inputs (exp=0) are treated as signed zero.
  - A result whose exponent would drop to ≤0 is flushed to signed zero with o=0.
- Exact cancellation (x−x) gives +0 (0x00000000).
- Zero operands:
  - (−0)+(−0) = −0.
  - Any other zero-only sum is +0.
  - A zero operand returns the other operand unchanged, with b's sign adjusted by op.
- Specials:
  - Any NaN input gives out=0x7FC00000.
  - inf+(−inf), including op-adjusted, gives 0x7FC00000.
  - Otherwise an infinite input passes through as signed infinity.
  - o=0 in all special cases.

Test Plan:
- Reset: assert rst mid-run → out=0x00000000 and o=0 without waiting for a clock edge. Release rst, apply a=0x3F800000, b=0x3F800000, op=0 → next edge out=0x40000000.
- Same exponent, add: a=0x0DEEEE00, b=0x0DEE0000, op=0 → next edge out=0x0E6E7700, o=0.
- Effective add via subtract: a=0xF5550005, b=0x7555000D, op=1 → out=0xF5D50009, o=0.
- Mixed signs, exponent difference 2: a=0xFEE30099, b=0x7DE00090, op=0 → out=0xFEAB0075, o=0.
- Massive cancellation with renormalization: a=0xD5551255, b=0xD5551250, op=1 → out=0xCAA00000, o=0.
- Overflow and specials:
  - a=b=0x7F7FFFFF, op=0 → out=0x7F800000, o=1.
  - a=0x7F800000, b=0x7F800000, op=1 → out=0x7FC00000, o=0.
  - a=b=0x40490FDB, op=1 → out=0x00000000.
